// File: rtl/hand_controller.sv
// Paddle-hand controller: frame-tick timebase, key synchronise/debounce,
// IDLE/MOVE/SWING state machine driving a clipped hand position and speed.
module hand_controller #(
  parameter int unsigned TICK_DIV    = 219089,
  parameter int unsigned DEB_TICKS   = 2,
  parameter logic [8:0]  MIN_Y       = 9'd0,
  parameter logic [8:0]  MAX_Y       = 9'd309,
  parameter logic [8:0]  HOME        = 9'd150,
  parameter int unsigned STEP_MAX    = 15,
  parameter logic [7:0]  SWING_V     = 8'd200,
  parameter int unsigned SWING_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_swing,
  input  logic [8:0] pic_y,
  output logic [8:0] handline,
  output logic [7:0] hand_velocity,
  output logic       frame_tick,
  output logic       contact
);

  localparam int unsigned CW = $clog2(TICK_DIV + 1);
  localparam int unsigned DW = $clog2(DEB_TICKS + 1);
  localparam int unsigned SW = $clog2(STEP_MAX + 1);
  localparam int unsigned KW = $clog2(SWING_TICKS + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, SWING} state_e;

  logic [CW-1:0] cnt_q;
  logic [2:0]    keys, sync1_q, sync2_q, deb_q, deb_d;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];

  state_e        state_q, mv_state;
  logic [SW-1:0] step_q, mv_step;
  logic [KW-1:0] swcnt_q;
  logic [8:0]    handline_q, mv_hl, hl_d, delta;
  logic [7:0]    vel_q, mv_vel;
  logic          contact_q, swing_edge, take_move;
  logic [9:0]    step10, sum10;
  logic [11:0]   vprod;

  assign frame_tick    = (cnt_q == CW'(TICK_DIV - 1));
  assign handline      = handline_q;
  assign hand_velocity = vel_q;
  assign contact       = contact_q;
  assign keys          = {key_swing, key_down, key_up};

  always_ff @(posedge clk) begin
    if (rst)             cnt_q <= '0;
    else if (frame_tick) cnt_q <= '0;
    else                 cnt_q <= cnt_q + 1'b1;
  end

  // Stability counter only advances on ticks where the synced level disagrees.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned k = 0; k < 3; k++) begin
      dcnt_d[k] = dcnt_q[k];
      if (frame_tick) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (dcnt_q[k] == DW'(DEB_TICKS - 1)) begin
            deb_d[k]  = sync2_q[k];
            dcnt_d[k] = '0;
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end else begin
          dcnt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int unsigned k = 0; k < 3; k++) dcnt_q[k] <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int unsigned k = 0; k < 3; k++) dcnt_q[k] <= dcnt_d[k];
    end
  end

  // Candidate move outcome; only applied when no swing is active or starting.
  always_comb begin
    swing_edge = deb_d[2] & ~deb_q[2];
    case ({deb_d[0], deb_d[1]})
      2'b10:   mv_state = MOVE_UP;
      2'b01:   mv_state = MOVE_DOWN;
      default: mv_state = IDLE;
    endcase
    if (mv_state == IDLE)         mv_step = '0;
    else if (mv_state != state_q) mv_step = SW'(1);
    else if (step_q >= SW'(STEP_MAX)) mv_step = SW'(STEP_MAX);
    else                          mv_step = step_q + 1'b1;
    step10 = 10'(mv_step);
    sum10  = 10'(handline_q) + step10;
    mv_hl  = handline_q;
    if (mv_state == MOVE_UP) begin
      if (10'(handline_q) >= 10'(MIN_Y) + step10) mv_hl = 9'(10'(handline_q) - step10);
      else                                        mv_hl = MIN_Y;
    end else if (mv_state == MOVE_DOWN) begin
      if (sum10 > 10'(MAX_Y)) mv_hl = MAX_Y;
      else                    mv_hl = sum10[8:0];
    end
    delta     = (mv_hl >= handline_q) ? (mv_hl - handline_q) : (handline_q - mv_hl);
    vprod     = {delta, 3'b000};
    mv_vel    = (|vprod[11:8]) ? 8'hFF : vprod[7:0];
    take_move = (state_q != SWING) && !swing_edge;
    hl_d      = take_move ? mv_hl : handline_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      swcnt_q    <= '0;
      handline_q <= HOME;
      vel_q      <= '0;
      contact_q  <= 1'b0;
    end else begin
      contact_q <= 1'b0;
      if (frame_tick) begin
        contact_q <= (pic_y < hl_d);
        if (state_q != SWING && swing_edge) begin
          state_q <= SWING;
          swcnt_q <= KW'(SWING_TICKS);
          step_q  <= '0;
          vel_q   <= SWING_V;
        end else if (state_q == SWING) begin
          step_q <= '0;
          if (swcnt_q <= KW'(1)) begin
            state_q <= IDLE;
            swcnt_q <= '0;
            vel_q   <= '0;
          end else begin
            swcnt_q <= swcnt_q - 1'b1;
            vel_q   <= SWING_V;
          end
        end else begin
          state_q    <= mv_state;
          step_q     <= mv_step;
          handline_q <= mv_hl;
          vel_q      <= mv_vel;
        end
      end
    end
  end

endmodule

// File: tb/tb_hand_controller.sv
// Directed per-tick vector bench for hand_controller with a 4-cycle frame tick.
module tb_hand_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_swing = 1'b0;
  logic [8:0] pic_y = 9'd200;
  logic [8:0] handline;
  logic [7:0] hand_velocity;
  logic       frame_tick, contact;

  int n_vec = 0;
  int n_bad = 0;

  hand_controller #(
    .TICK_DIV(4),
    .DEB_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down),
    .key_swing(key_swing), .pic_y(pic_y), .handline(handline),
    .hand_velocity(hand_velocity), .frame_tick(frame_tick), .contact(contact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic       up, dn, sw;
    logic [8:0] pic;
    logic [8:0] hl;
    logic [7:0] vel;
    logic       ct;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int u, int d, int s, int p, int h, int v, int c);
    vec_t x;
    x.pre_rst = 1'(r); x.up = 1'(u); x.dn = 1'(d); x.sw = 1'(s);
    x.pic = 9'(p); x.hl = 9'(h); x.vel = 8'(v); x.ct = 1'(c);
    return x;
  endfunction

  task automatic check_out(input string name, input logic [8:0] hl,
                           input logic [7:0] vel, input logic ct);
    n_vec++;
    if (handline !== hl || hand_velocity !== vel || contact !== ct) begin
      n_bad++;
      $display("FAIL %s: handline=%0d velocity=%0d contact=%b, expected %0d/%0d/%b",
               name, handline, hand_velocity, contact, hl, vel, ct);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: frame_tick timeout, got none, expected one within 16 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    key_up = 1'b0; key_down = 1'b0; key_swing = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_out(name, 9'd150, 8'd0, 1'b0);
    check_bit({name, "_tick"}, frame_tick, 1'b0);
  endtask

  initial begin
    // pre, up, dn, sw, pic_y, handline, velocity, contact
    tbl.push_back(mk(0,1,0,0,200,150,  0,0));
    tbl.push_back(mk(0,0,0,0,200,150,  0,0));
    tbl.push_back(mk(0,0,0,0,100,150,  0,1));
    tbl.push_back(mk(0,0,0,0,100,150,  0,1));
    tbl.push_back(mk(0,1,0,0,100,150,  0,1));
    tbl.push_back(mk(0,1,0,0,100,149,  8,1));
    tbl.push_back(mk(0,1,0,0,100,147, 16,1));
    tbl.push_back(mk(0,1,0,0,200,144, 24,0));
    tbl.push_back(mk(0,1,0,0,139,140, 32,1));
    tbl.push_back(mk(0,1,0,0,135,135, 40,0));
    tbl.push_back(mk(0,0,0,0,128,129, 48,1));
    tbl.push_back(mk(0,0,0,0,129,129,  0,0));
    tbl.push_back(mk(0,0,0,0,200,129,  0,0));
    tbl.push_back(mk(1,0,1,0,200,150,  0,0));
    tbl.push_back(mk(0,0,1,0,200,151,  8,0));
    tbl.push_back(mk(0,0,1,0,200,153, 16,0));
    tbl.push_back(mk(0,0,1,0,200,156, 24,0));
    tbl.push_back(mk(0,0,1,0,200,160, 32,0));
    tbl.push_back(mk(0,0,1,0,200,165, 40,0));
    tbl.push_back(mk(0,0,1,0,200,171, 48,0));
    tbl.push_back(mk(0,0,1,0,200,178, 56,0));
    tbl.push_back(mk(0,0,1,0,200,186, 64,0));
    tbl.push_back(mk(0,0,1,0,200,195, 72,0));
    tbl.push_back(mk(0,0,1,0,200,205, 80,1));
    tbl.push_back(mk(0,0,1,0,200,216, 88,1));
    tbl.push_back(mk(0,0,1,0,200,228, 96,1));
    tbl.push_back(mk(0,0,1,0,200,241,104,1));
    tbl.push_back(mk(0,0,1,0,200,255,112,1));
    tbl.push_back(mk(0,0,1,0,200,270,120,1));
    tbl.push_back(mk(0,0,1,0,200,285,120,1));
    tbl.push_back(mk(0,0,1,0,200,300,120,1));
    tbl.push_back(mk(0,0,1,0,200,309, 72,1));
    tbl.push_back(mk(0,0,1,0,200,309,  0,1));
    tbl.push_back(mk(0,1,0,0,300,309,  0,1));
    tbl.push_back(mk(0,1,0,0,300,308,  8,1));
    tbl.push_back(mk(0,1,0,0,300,306, 16,1));
    tbl.push_back(mk(0,1,0,0,300,303, 24,1));
    tbl.push_back(mk(0,1,0,1,298,299, 32,1));
    tbl.push_back(mk(0,1,0,1,298,299,200,1));
    tbl.push_back(mk(0,1,0,0,298,299,200,1));
    tbl.push_back(mk(0,1,0,0,298,299,200,1));
    tbl.push_back(mk(0,1,0,1,298,299,200,1));
    tbl.push_back(mk(0,1,0,1,298,299,  0,1));
    tbl.push_back(mk(0,1,0,1,298,298,  8,0));
    tbl.push_back(mk(0,0,0,0,298,296, 16,0));
    tbl.push_back(mk(0,0,0,0,298,296,  0,0));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset", 9'd150, 8'd0, 1'b0);
    check_bit("reset_tick", frame_tick, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset($sformatf("row%0d_rst", i));
      key_up = tbl[i].up; key_down = tbl[i].dn; key_swing = tbl[i].sw;
      pic_y = tbl[i].pic;
      wait_tick($sformatf("row%0d", i));
      check_out($sformatf("row%0d", i), tbl[i].hl, tbl[i].vel, tbl[i].ct);
      @(posedge clk);
      #1;
      check_bit($sformatf("row%0d_pulse", i), contact, 1'b0);
    end

    // Reset one cycle into a swing: aborts it and restarts the tick timebase.
    key_swing = 1'b1;
    wait_tick("sw_deb");
    check_out("sw_deb", 9'd296, 8'd0, 1'b0);
    wait_tick("sw_entry");
    check_out("sw_entry", 9'd296, 8'd200, 1'b0);
    do_reset("rst_mid_swing");
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      check_bit($sformatf("rst_tick_c%0d", c), frame_tick, (c == 3) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    #1;
    check_out("post_rst", 9'd150, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
